regfile_ooo_scoreboard: RTL and testbench
=========================================

Name: regfile_ooo_scoreboard

Overview:
Parametrised successor to the out-of-order architectural register file: NUM_READ read ports plus a commit-side read port, a single commit write port, and a per-register busy/ROB-tag scoreboard. Dispatch marks a destination busy with its ROB tag. Commit writes data and clears busy only when the tags match. Flush clears all busy state. Sits between rename/dispatch and the ROB commit stage.

Parameters:
DATA_W, 64, data width per register
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS
NUM_READ, 2, number of operand read ports
TAG_W, 4, ROB tag width
ZERO_REG, 31, hardwired-zero register index; set to NUM_REGS to disable

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
rd_addr_i  in  NUM_READ*ADDR_W  operand read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_READ*DATA_W  operand read data
rd_busy_o  out  NUM_READ  operand register busy (pending producer)
rd_tag_o  out  NUM_READ*TAG_W  ROB tag of pending producer
dispatch_valid_i  in  1  mark destination busy
dispatch_addr_i  in  ADDR_W  destination register
dispatch_tag_i  in  TAG_W  ROB tag of producer
commit_valid_i  in  1  commit write enable
commit_addr_i  in  ADDR_W  commit destination
commit_tag_i  in  TAG_W  ROB tag of committing instruction
commit_data_i  in  DATA_W  commit write data
flush_i  in  1  mispredict/exception flush
commit_rd_addr_i  in  ADDR_W  commit-side read address
commit_rd_data_o  out  DATA_W  commit-side read data
busy_count_o  out  ADDR_W+1  registered number of busy registers

Behaviour:
- Reset (reset_n=0, async): all data=0, busy=0, tags=0, busy_count_o=0. Reads return 0 and busy=0 during reset.
- State: data[NUM_REGS], busy[NUM_REGS], tag[NUM_REGS]. All updates occur on the rising clk edge.
- Commit write: if commit_valid_i, addr valid and not ZERO_REG, then data[addr] <= commit_data_i, unconditionally (in-order commit).
- Commit clear: if commit_valid_i and busy[addr] and tag[addr]==commit_tag_i, then busy[addr] <= 0. Tag mismatch leaves busy/tag untouched, because a younger producer still owns the register.
- Dispatch: if dispatch_valid_i, not flush_i, addr valid and not ZERO_REG, then busy <= 1 and tag <= dispatch_tag_i. Re-dispatch to an already-busy register overwrites the tag.
- Same register, dispatch and commit in one cycle: data is written; dispatch wins, so busy=1 and tag=dispatch_tag_i.
- Flush: busy <= 0 for all registers next edge; tags unchanged. Commit write in the same cycle still updates data. Dispatch in the same cycle is dropped.
- Reads (operand and commit-side) are combinational, zero latency.
- Write-through bypass: if commit_valid_i and commit_addr_i==read addr (valid, not ZERO_REG), rd_data_o/commit_rd_data_o = commit_data_i.
- Busy bypass: rd_busy_o = busy[a] AND NOT (commit_valid_i AND commit_addr_i==a AND commit_tag_i==tag[a]). Dispatch in the same cycle is NOT visible on reads.
- rd_tag_o always shows tag[a], regardless of busy.
- ZERO_REG and addresses >= NUM_REGS: read data 0, busy 0, tag 0; writes and dispatches are ignored.
- busy_count_o: registered popcount of busy[] after each update. It reaches 0 the cycle after a flush.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion behaves as normal.

Test Plan:
- Reset then read all regs on both ports -> data 0, busy 0, busy_count_o 0. Commit reg31 data 0xA0 -> reg31 reads 0.
- Dispatch r5 tag 3; next cycle rd port0=r5 -> busy 1, tag 3, count 1. Commit r5 tag 3 data 0x1234 -> same cycle data 0x1234 and busy 0 (bypass); next cycle busy 0, count 0.
- Dispatch r7 tag 2, then r7 tag 9; commit r7 tag 2 data 0xAA -> data 0xAA, busy stays 1, tag 9. Commit r7 tag 9 -> busy 0.
- Same cycle: dispatch r4 tag 6 and commit r4 tag 1 (r4 busy with tag 1) data 0x55 -> next cycle data 0x55, busy 1, tag 6.
- Dispatch r1..r10, then flush_i with dispatch r11 and commit r2 data 0x77 -> next cycle all busy 0, count 0, r11 not busy, r2=0x77.
- Dispatch r3, then pulse reset_n low mid-cycle -> outputs 0 immediately, busy 0. Write pattern i*0x0000010204080001 to r0..r30 and check it on both ports and the commit port.

Source files
------------

// File: rtl/regfile_ooo_scoreboard.sv
// Architectural register file with per-register busy/ROB-tag scoreboard.
// Combinational reads with commit write-through and busy bypass; one commit write port.
module regfile_ooo_scoreboard #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int TAG_W    = 4,
    parameter int ZERO_REG = 31
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_READ*DATA_W-1:0] rd_data_o,
    output logic [NUM_READ-1:0]        rd_busy_o,
    output logic [NUM_READ*TAG_W-1:0]  rd_tag_o,
    input  logic                       dispatch_valid_i,
    input  logic [ADDR_W-1:0]          dispatch_addr_i,
    input  logic [TAG_W-1:0]           dispatch_tag_i,
    input  logic                       commit_valid_i,
    input  logic [ADDR_W-1:0]          commit_addr_i,
    input  logic [TAG_W-1:0]           commit_tag_i,
    input  logic [DATA_W-1:0]          commit_data_i,
    input  logic                       flush_i,
    input  logic [ADDR_W-1:0]          commit_rd_addr_i,
    output logic [DATA_W-1:0]          commit_rd_data_o,
    output logic [ADDR_W:0]            busy_count_o
);

    logic [DATA_W-1:0]   data_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_q  [NUM_REGS];
    logic [TAG_W-1:0]    tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     busy_count_d;
    logic                commit_en;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && (int'(a) != ZERO_REG);
    endfunction

    // Bypass paths are gated so reads show cleared state while reset is held.
    assign commit_en = commit_valid_i & reset_n;

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush_i) begin
                busy_d[r] = 1'b0;
            end else begin
                if (commit_valid_i && int'(commit_addr_i) == r && busy_q[r] &&
                    tag_q[r] == commit_tag_i) begin
                    busy_d[r] = 1'b0;
                end
                // Dispatch is applied after the commit clear so it wins on the same register.
                if (dispatch_valid_i && int'(dispatch_addr_i) == r && r != ZERO_REG) begin
                    busy_d[r] = 1'b1;
                    tag_d[r]  = dispatch_tag_i;
                end
            end
        end
        busy_count_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q       <= '0;
            busy_count_o <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_o <= busy_count_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= tag_d[r];
                if (commit_valid_i && int'(commit_addr_i) == r && r != ZERO_REG) begin
                    data_q[r] <= commit_data_i;
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        logic [TAG_W-1:0]  t;
        a                = '0;
        d                = '0;
        b                = 1'b0;
        t                = '0;
        rd_data_o        = '0;
        rd_busy_o        = '0;
        rd_tag_o         = '0;
        commit_rd_data_o = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            a = rd_addr_i[k*ADDR_W +: ADDR_W];
            d = '0;
            b = 1'b0;
            t = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (int'(a) == r && addr_ok(a)) begin
                    d = data_q[r];
                    t = tag_q[r];
                    b = busy_q[r] & ~(commit_en && commit_addr_i == a && commit_tag_i == tag_q[r]);
                end
            end
            if (addr_ok(a) && commit_en && commit_addr_i == a) begin
                d = commit_data_i;
            end
            rd_data_o[k*DATA_W +: DATA_W] = d;
            rd_busy_o[k]                  = b;
            rd_tag_o[k*TAG_W +: TAG_W]    = t;
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(commit_rd_addr_i) == r && addr_ok(commit_rd_addr_i)) begin
                commit_rd_data_o = data_q[r];
            end
        end
        if (addr_ok(commit_rd_addr_i) && commit_en && commit_addr_i == commit_rd_addr_i) begin
            commit_rd_data_o = commit_data_i;
        end
    end

endmodule

// File: tb/tb_regfile_ooo_scoreboard.sv
// Bench for regfile_ooo_scoreboard: directed plan steps then random traffic
// against an array-based reference model of the register/scoreboard rules.
module tb_regfile_ooo_scoreboard;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_READ = 2;
    localparam int TAG_W    = 4;
    localparam int ZERO_REG = 31;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic [NUM_READ*ADDR_W-1:0] rd_addr;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0]        rd_busy;
    logic [NUM_READ*TAG_W-1:0]  rd_tag;
    logic                       dv = 0, cv = 0, fl = 0;
    logic [ADDR_W-1:0]          da = 0, ca = 0, cra = 0, ra0 = 0, ra1 = 0;
    logic [TAG_W-1:0]           dt = 0, ct = 0;
    logic [DATA_W-1:0]          cd = 0;
    logic [DATA_W-1:0]          commit_rd_data;
    logic [ADDR_W:0]            busy_count;

    assign rd_addr = {ra1, ra0};

    regfile_ooo_scoreboard #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .NUM_READ(NUM_READ), .TAG_W(TAG_W), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy), .rd_tag_o(rd_tag),
        .dispatch_valid_i(dv), .dispatch_addr_i(da), .dispatch_tag_i(dt),
        .commit_valid_i(cv), .commit_addr_i(ca), .commit_tag_i(ct), .commit_data_i(cd),
        .flush_i(fl), .commit_rd_addr_i(cra), .commit_rd_data_o(commit_rd_data),
        .busy_count_o(busy_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] m_data [NUM_REGS];
    logic              m_busy [NUM_REGS];
    logic [TAG_W-1:0]  m_tag  [NUM_REGS];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic bit ok(input int a);
        return a < NUM_REGS && a != ZERO_REG;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int a);
        if (!ok(a) || !reset_n) return '0;
        if (cv && int'(ca) == a) return cd;
        return m_data[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (!ok(a) || !reset_n) return 1'b0;
        return m_busy[a] && !(cv && int'(ca) == a && ct == m_tag[a]);
    endfunction

    function automatic logic [TAG_W-1:0] exp_tag(input int a);
        if (!ok(a)) return '0;
        return m_tag[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < NUM_REGS; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
    endtask

    task automatic model_edge();
        logic nb [NUM_REGS];
        for (int r = 0; r < NUM_REGS; r++) nb[r] = m_busy[r];
        if (flush_i_active()) begin
            for (int r = 0; r < NUM_REGS; r++) nb[r] = 1'b0;
        end else begin
            if (cv && m_busy[ca] && m_tag[ca] == ct) nb[ca] = 1'b0;
            if (dv && ok(int'(da))) begin
                nb[da] = 1'b1;
                m_tag[da] = dt;
            end
        end
        if (cv && ok(int'(ca))) m_data[ca] = cd;
        for (int r = 0; r < NUM_REGS; r++) m_busy[r] = nb[r];
    endtask

    function automatic bit flush_i_active();
        return fl;
    endfunction

    task automatic idle();
        dv = 0; cv = 0; fl = 0; ct = 0; cd = '0; da = 0; dt = 0; ca = 0;
    endtask

    task automatic check_ports();
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < NUM_READ; k++) begin
            a = (k == 0) ? ra0 : ra1;
            chk($sformatf("rd_data[%0d] a=%0d", k, a), rd_data[k*DATA_W +: DATA_W], exp_data(int'(a)));
            chk($sformatf("rd_busy[%0d] a=%0d", k, a), 64'(rd_busy[k]), 64'(exp_busy(int'(a))));
            chk($sformatf("rd_tag[%0d] a=%0d", k, a), 64'(rd_tag[k*TAG_W +: TAG_W]), 64'(exp_tag(int'(a))));
        end
        chk($sformatf("commit_rd_data a=%0d", cra), commit_rd_data, exp_data(int'(cra)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        chk("busy_count", 64'(busy_count), 64'(m_count()));
    endtask

    task automatic sweep();
        idle();
        for (int a = 0; a < NUM_REGS; a++) begin
            ra0 = ADDR_W'(a); ra1 = ADDR_W'(NUM_REGS - 1 - a); cra = ADDR_W'(a);
            #1;
            check_ports();
        end
    endtask

    initial begin
        model_reset();
        // Reset held: bypass must not leak through.
        cv = 1; ca = 3; cd = 64'h55; ra0 = 3; cra = 3;
        #2;
        chk("rst_rd_data", rd_data[DATA_W-1:0], 64'h0);
        chk("rst_commit_rd", commit_rd_data, 64'h0);
        chk("rst_count", 64'(busy_count), 64'h0);
        idle();
        #10 reset_n = 1;
        #4;
        sweep();

        // ZERO_REG ignores writes.
        cv = 1; ca = 31; cd = 64'hA0; ra0 = 31;
        #1 check_ports();
        tick(); idle(); ra0 = 31; #1;
        chk("zero_reg_data", rd_data[DATA_W-1:0], 64'h0);

        // Dispatch then commit with matching tag.
        dv = 1; da = 5; dt = 3;
        tick(); idle(); ra0 = 5; #1;
        check_ports();
        chk("r5_busy", 64'(rd_busy[0]), 64'h1);
        chk("r5_tag", 64'(rd_tag[TAG_W-1:0]), 64'h3);
        chk("r5_count", 64'(busy_count), 64'h1);
        cv = 1; ca = 5; ct = 3; cd = 64'h1234; #1;
        check_ports();
        chk("r5_bypass_data", rd_data[DATA_W-1:0], 64'h1234);
        chk("r5_bypass_busy", 64'(rd_busy[0]), 64'h0);
        tick(); idle(); #1;
        check_ports();
        chk("r5_count_after", 64'(busy_count), 64'h0);

        // Tag mismatch leaves the younger producer's ownership in place.
        dv = 1; da = 7; dt = 2; tick();
        dv = 1; da = 7; dt = 9; tick();
        idle(); cv = 1; ca = 7; ct = 2; cd = 64'hAA; tick();
        idle(); ra0 = 7; #1;
        check_ports();
        chk("r7_data", rd_data[DATA_W-1:0], 64'hAA);
        chk("r7_busy_kept", 64'(rd_busy[0]), 64'h1);
        chk("r7_tag", 64'(rd_tag[TAG_W-1:0]), 64'h9);
        cv = 1; ca = 7; ct = 9; cd = 64'hAB; tick();
        idle(); #1;
        chk("r7_busy_clear", 64'(rd_busy[0]), 64'h0);

        // Dispatch and commit on the same register: dispatch wins busy/tag.
        dv = 1; da = 4; dt = 1; tick();
        idle(); dv = 1; da = 4; dt = 6; cv = 1; ca = 4; ct = 1; cd = 64'h55; tick();
        idle(); ra0 = 4; #1;
        check_ports();
        chk("r4_data", rd_data[DATA_W-1:0], 64'h55);
        chk("r4_busy", 64'(rd_busy[0]), 64'h1);
        chk("r4_tag", 64'(rd_tag[TAG_W-1:0]), 64'h6);

        // Flush drops concurrent dispatch but keeps commit data.
        for (int i = 1; i <= 10; i++) begin
            idle(); dv = 1; da = ADDR_W'(i); dt = TAG_W'(i); tick();
        end
        idle(); fl = 1; dv = 1; da = 11; dt = 5; cv = 1; ca = 2; ct = 0; cd = 64'h77; tick();
        idle(); ra0 = 11; ra1 = 2; #1;
        chk("flush_count", 64'(busy_count), 64'h0);
        chk("flush_r11_busy", 64'(rd_busy[0]), 64'h0);
        chk("flush_r2_data", rd_data[2*DATA_W-1:DATA_W], 64'h77);
        sweep();

        // Mid-cycle reset clears outputs immediately.
        dv = 1; da = 3; dt = 4; tick();
        idle(); ra0 = 3; ra1 = 2; #2;
        reset_n = 0; model_reset(); #1;
        chk("mid_rst_busy", 64'(rd_busy[0]), 64'h0);
        chk("mid_rst_r2", rd_data[2*DATA_W-1:DATA_W], 64'h0);
        chk("mid_rst_count", 64'(busy_count), 64'h0);
        @(negedge clk); reset_n = 1; #1;
        for (int i = 0; i < 31; i++) begin
            idle(); cv = 1; ca = ADDR_W'(i); cd = 64'(i) * 64'h0000010204080001; tick();
        end
        sweep();
        idle(); ra0 = 30; #1;
        chk("pattern_r30", rd_data[DATA_W-1:0], 64'd30 * 64'h0000010204080001);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle();
            dv  = ($urandom_range(0, 1) == 1);
            da  = ADDR_W'($urandom_range(0, 31));
            dt  = TAG_W'($urandom_range(0, 15));
            cv  = ($urandom_range(0, 1) == 1);
            ca  = ADDR_W'($urandom_range(0, 31));
            ct  = ($urandom_range(0, 1) == 1) ? m_tag[ca] : TAG_W'($urandom_range(0, 15));
            cd  = {$urandom, $urandom};
            fl  = ($urandom_range(0, 15) == 0);
            ra0 = ($urandom_range(0, 3) == 0) ? ca : ADDR_W'($urandom_range(0, 31));
            ra1 = ADDR_W'($urandom_range(0, 31));
            cra = ($urandom_range(0, 3) == 0) ? ca : ADDR_W'($urandom_range(0, 31));
            #1;
            check_ports();
            tick();
        end
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
